spi_adc4ch: RTL and testbench

Scan controller for a 4-channel 12-bit SPI ADC with an MCP3204-style 24-bit byte-mode frame. A rising edge on `button_i` starts one scan: four back-to-back SPI frames (channels 0..3, single-ended). Each frame captures one 12-bit result. After the fourth frame, all four result registers update together and `eos_o` pulses. The block sits between the board push-button/ADC pins and downstream logic that consumes `doutchN_o`.

---
 rtl/spi_adc4ch.sv | 260 ++++++++++++++++++++++++++
 tb/tb_spi_adc4ch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc4ch.sv
// -----------------------------------------------------------------------------
// spi_adc4ch
// Scan controller for a 4-channel 12-bit SPI ADC (MCP3204-style, 24-bit
// byte-mode frame). A rising edge on button_i starts one scan of channels
// 0..3. Each frame's 12-bit result is staged. After the fourth frame, all four
// outputs update together and eos_o pulses for one cycle.
//
// Parameters:
//   CLK_DIV   dclk_o half-period in clk_i cycles (>= 2)
//   CS_GAP    clk_i cycles that cs_o stays high between frames (>= 1)
//
// Ports:
//   clk_i              system clock
//   rst_i              synchronous active-high reset
//   button_i           scan request (rising edge)
//   miso_i             ADC serial data out
//   mosi_o             ADC serial data in
//   dclk_o             SPI clock, mode 0
//   cs_o               ADC chip select, active-low
//   eos_o              end-of-scan, one-cycle pulse
//   doutch0_o..3_o     last completed conversion, channels 0..3
//
// Build option:
//   SPI_ADC4CH_BTN_SYNC_EN  when defined, button_i passes through a 2-flop
//                           synchronizer before edge detection (+2 cycles of
//                           start latency). When undefined, it is used directly.
// -----------------------------------------------------------------------------
module spi_adc4ch #(
    parameter int CLK_DIV = 20,
    parameter int CS_GAP  = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        button_i,
    input  logic        miso_i,
    output logic        mosi_o,
    output logic        dclk_o,
    output logic        cs_o,
    output logic        eos_o,
    output logic [11:0] doutch0_o,
    output logic [11:0] doutch1_o,
    output logic [11:0] doutch2_o,
    output logic [11:0] doutch3_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    // Command word for a single-ended conversion of channel ch, MSB first.
    function automatic logic [23:0] f_mosi_word(input logic [1:0] ch);
        return {5'b00000, 1'b1, 1'b1, 1'b0, ch, 14'b0};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_btn_q;
    logic        r_mosi;
    logic        r_dclk;
    logic        r_cs;
    logic        r_eos;
    logic [15:0] r_cnt;
    logic [4:0]  r_bit;
    logic [1:0]  r_ch;
    logic [11:0] r_shift;
    logic [11:0] r_stage [4];
    logic [11:0] r_dout0;
    logic [11:0] r_dout1;
    logic [11:0] r_dout2;
    logic [11:0] r_dout3;

    logic        w_btn;
    logic        w_start;
    logic        w_phase_end;
    logic        w_frame_end;
    logic        w_gap_end;
    logic [4:0]  w_bit_nxt;
    logic [1:0]  w_ch_nxt;
    logic [23:0] w_word;
    logic [23:0] w_word_ch0;
    logic [23:0] w_word_nxt;

`ifdef SPI_ADC4CH_BTN_SYNC_EN
    logic [1:0] r_btn_sync;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_sync <= 2'b00;
        end else begin
            r_btn_sync <= {r_btn_sync[0], button_i};
        end
    end

    assign w_btn = r_btn_sync[1];
`else
    assign w_btn = button_i;
`endif

    assign w_start     = w_btn & ~r_btn_q;
    assign w_phase_end = (r_state == ST_FRAME) && (r_cnt == DIV_LAST);
    assign w_frame_end = w_phase_end && r_dclk && (r_bit == 5'd23);
    assign w_gap_end   = (r_state == ST_GAP) && (r_cnt == GAP_LAST);
    assign w_bit_nxt   = r_bit + 5'd1;
    assign w_ch_nxt    = r_ch + 2'd1;
    assign w_word      = f_mosi_word(r_ch);
    assign w_word_ch0  = f_mosi_word(2'd0);
    assign w_word_nxt  = f_mosi_word(w_ch_nxt);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; starts are only honoured in IDLE, so busy edges are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_FRAME;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (w_frame_end) begin
                    if (r_ch == 2'd3) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end else begin
                    w_state_nxt = ST_FRAME;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = ST_FRAME;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // SPI datapath: pin registers, phase/bit counters, capture and staging.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_q    <= 1'b0;
            r_mosi     <= 1'b0;
            r_dclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_eos      <= 1'b0;
            r_cnt      <= 16'd0;
            r_bit      <= 5'd0;
            r_ch       <= 2'd0;
            r_shift    <= 12'd0;
            r_stage[0] <= 12'd0;
            r_stage[1] <= 12'd0;
            r_stage[2] <= 12'd0;
            r_stage[3] <= 12'd0;
            r_dout0    <= 12'd0;
            r_dout1    <= 12'd0;
            r_dout2    <= 12'd0;
            r_dout3    <= 12'd0;
        end else begin
            r_btn_q <= w_btn;
            r_eos   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cs   <= 1'b0;
                        r_dclk <= 1'b0;
                        r_mosi <= w_word_ch0[23];
                        r_cnt  <= 16'd0;
                        r_bit  <= 5'd0;
                        r_ch   <= 2'd0;
                    end
                end
                ST_FRAME: begin
                    if (w_phase_end) begin
                        r_cnt <= 16'd0;
                        if (!r_dclk) begin
                            // Rising dclk: sample MISO. Only the last 12 samples
                            // survive in the shift register, which is the result.
                            r_dclk  <= 1'b1;
                            r_shift <= {r_shift[10:0], miso_i};
                        end else if (r_bit == 5'd23) begin
                            r_dclk        <= 1'b0;
                            r_cs          <= 1'b1;
                            r_mosi        <= 1'b0;
                            r_stage[r_ch] <= r_shift;
                            if (r_ch == 2'd3) begin
                                // Outputs and eos become visible together in the
                                // DONE cycle; channel 3 comes straight from the
                                // shifter because its stage is written this edge.
                                r_eos   <= 1'b1;
                                r_dout0 <= r_stage[0];
                                r_dout1 <= r_stage[1];
                                r_dout2 <= r_stage[2];
                                r_dout3 <= r_shift;
                            end
                        end else begin
                            r_dclk <= 1'b0;
                            r_bit  <= w_bit_nxt;
                            r_mosi <= w_word[5'd23 - w_bit_nxt];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_cs   <= 1'b0;
                        r_mosi <= w_word_nxt[23];
                        r_cnt  <= 16'd0;
                        r_bit  <= 5'd0;
                        r_ch   <= w_ch_nxt;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_cnt <= 16'd0;
                end
                default: begin
                    r_cnt <= 16'd0;
                end
            endcase
        end
    end

    assign mosi_o    = r_mosi;
    assign dclk_o    = r_dclk;
    assign cs_o      = r_cs;
    assign eos_o     = r_eos;
    assign doutch0_o = r_dout0;
    assign doutch1_o = r_dout1;
    assign doutch2_o = r_dout2;
    assign doutch3_o = r_dout3;

endmodule

// File: tb/tb_spi_adc4ch.sv
// -----------------------------------------------------------------------------
// tb_spi_adc4ch
// Self-checking bench for spi_adc4ch. A behavioural ADC watches the SPI pins,
// decodes the channel from the command bits and returns a per-channel 12-bit
// value (random junk on the non-result bits). A pin monitor records every
// cs_o-low window (length, dclk rises, MOSI word, start cycle) and eos pulses.
// Expectations come from the frame/scan arithmetic and the ADC value table.
// -----------------------------------------------------------------------------
module tb_spi_adc4ch;

    localparam int CLK_DIV   = 20;
    localparam int CS_GAP    = 40;
    localparam int FRAME_LEN = 48 * CLK_DIV;
    localparam int SCAN_LEN  = 1 + 4 * FRAME_LEN + 3 * CS_GAP;
`ifdef SPI_ADC4CH_BTN_SYNC_EN
    localparam int START_LAT = 3;
`else
    localparam int START_LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic        button;
    logic        miso;
    logic        mosi;
    logic        dclk;
    logic        cs;
    logic        eos;
    logic [11:0] dout0;
    logic [11:0] dout1;
    logic [11:0] dout2;
    logic [11:0] dout3;

    spi_adc4ch #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .button_i (button),
        .miso_i   (miso),
        .mosi_o   (mosi),
        .dclk_o   (dclk),
        .cs_o     (cs),
        .eos_o    (eos),
        .doutch0_o(dout0),
        .doutch1_o(dout1),
        .doutch2_o(dout2),
        .doutch3_o(dout3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // monitor / ADC model state
    int          clr_gen  = 0;
    int          seen_gen = 0;
    int          q_fall[$];
    int          q_len[$];
    int          q_rise[$];
    logic [23:0] q_word[$];
    int          eos_cnt  = 0;
    int          eos_cyc  = 0;
    int          viol     = 0;
    logic [11:0] adc_val [4];
    bit          const_mode = 1'b0;

    initial begin
        logic        prev_cs;
        logic        prev_dclk;
        logic        prev_mosi;
        bit          in_frame;
        int          cur_len;
        int          cur_rises;
        logic [23:0] cur_word;
        logic [1:0]  dec_ch;
        logic [31:0] junk;
        logic [11:0] tmp;
        prev_cs   = 1'b1;
        prev_dclk = 1'b0;
        prev_mosi = 1'b0;
        in_frame  = 1'b0;
        cur_len   = 0;
        cur_rises = 0;
        cur_word  = 24'd0;
        dec_ch    = 2'd0;
        junk      = 32'd0;
        miso      = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                q_fall.delete();
                q_len.delete();
                q_rise.delete();
                q_word.delete();
                eos_cnt = 0;
                eos_cyc = 0;
                viol    = 0;
            end
            if (eos === 1'b1) begin
                eos_cnt++;
                if (eos_cnt == 1) eos_cyc = cyc;
            end
            if (cs === 1'b0 && prev_cs === 1'b1) begin
                in_frame  = 1'b1;
                cur_len   = 0;
                cur_rises = 0;
                cur_word  = 24'd0;
                junk      = $urandom;
                q_fall.push_back(cyc);
            end
            if (cs === 1'b0) begin
                cur_len++;
                if (dclk === 1'b1 && prev_dclk === 1'b0) begin
                    cur_rises++;
                    cur_word = {cur_word[22:0], mosi};
                    if (cur_rises == 10) dec_ch = cur_word[1:0];
                end
            end
            if (cs === 1'b1 && prev_cs === 1'b0 && in_frame) begin
                in_frame = 1'b0;
                q_len.push_back(cur_len);
                q_rise.push_back(cur_rises);
                q_word.push_back(cur_word);
            end
            if (cs === 1'b1 && dclk === 1'b1) viol++;
            if (mosi !== prev_mosi && !(prev_dclk === 1'b1 && dclk === 1'b0)) viol++;
            // ADC drives the bit for the upcoming dclk rise during the low phase
            if (const_mode) begin
                miso = 1'b1;
            end else if (cs === 1'b0 && dclk === 1'b0 && cur_rises < 24) begin
                if (cur_rises >= 12) begin
                    tmp  = adc_val[dec_ch];
                    miso = tmp[4'(23 - cur_rises)];
                end else begin
                    miso = junk[5'(cur_rises)];
                end
            end
            prev_cs   = cs;
            prev_dclk = dclk;
            prev_mosi = mosi;
        end
    end

    // One scan request; optional hold length and a second 1-cycle edge at off2.
    task automatic run_scan(input int plen, input int off2, input bit cmode);
        int          nscan;
        int          dur;
        int          press;
        logic [11:0] e;
        logic [11:0] got;
        // a second edge is accepted only once the first scan has left DONE
        nscan = (off2 > SCAN_LEN) ? 2 : 1;
        dur   = nscan * (SCAN_LEN + 200);
        if (plen > dur) dur = plen;
        dur += 300;
        const_mode = cmode;
        clr_gen++;
        @(negedge clk);
        @(negedge clk);
        press = cyc;
        for (int t = 0; t < dur; t++) begin
            button = (t < plen) || (t == off2);
            @(negedge clk);
        end
        button = 1'b0;
        check("eos_count", 32'(eos_cnt), 32'(nscan));
        check("frame_count", 32'(q_fall.size()), 32'(4 * nscan));
        check("frames_closed", 32'(q_len.size()), 32'(4 * nscan));
        for (int i = 0; i < q_len.size() && i < 4 * nscan; i++) begin
            check("frame_len", 32'(q_len[i]), 32'(FRAME_LEN));
            check("dclk_rises", 32'(q_rise[i]), 32'd24);
            check("mosi_word", 32'(q_word[i]), 32'h060000 + 32'((i % 4) * 32'h4000));
            if (i % 4 != 0) check("cs_gap", 32'(q_fall[i] - q_fall[i-1]), 32'(FRAME_LEN + CS_GAP));
        end
        if (q_fall.size() > 0) begin
            check("start_lat", 32'(q_fall[0] - press), 32'(START_LAT));
            check("scan_len", 32'(eos_cyc - q_fall[0]), 32'(SCAN_LEN - 1));
        end
        if (nscan == 2 && q_fall.size() > 4) begin
            check("restart_lat", 32'(q_fall[4] - press), 32'(off2 + START_LAT));
        end
        for (int c = 0; c < 4; c++) begin
            e = cmode ? 12'hFFF : adc_val[c];
            case (c)
                0:       got = dout0;
                1:       got = dout1;
                2:       got = dout2;
                default: got = dout3;
            endcase
            check("dout", 32'(got), 32'(e));
        end
        check("pin_rules", 32'(viol), 32'd0);
    endtask

    task automatic randomize_adc();
        for (int c = 0; c < 4; c++) adc_val[c] = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        int idle_bad;
        rst    = 1'b1;
        button = 1'b0;
        adc_val[0] = 12'h123;
        adc_val[1] = 12'h456;
        adc_val[2] = 12'h789;
        adc_val[3] = 12'hABC;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        idle_bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cs !== 1'b1 || dclk !== 1'b0 || mosi !== 1'b0 || eos !== 1'b0 ||
                dout0 !== 12'd0 || dout1 !== 12'd0 || dout2 !== 12'd0 || dout3 !== 12'd0)
                idle_bad++;
        end
        check("idle_cycles_bad", 32'(idle_bad), 32'd0);
        check("idle_cs", 32'(cs), 32'd1);
        check("idle_dclk", 32'(dclk), 32'd0);
        check("idle_dout3", 32'(dout3), 32'd0);

        run_scan(1, -1, 1'b1);           // constant MISO high
        run_scan(1, -1, 1'b0);           // fixed 0x123/0x456/0x789/0xABC
        randomize_adc();
        run_scan(1, 1500, 1'b0);         // second edge mid-scan is ignored
        randomize_adc();
        run_scan(6000, -1, 1'b0);        // button held high: one scan only
        randomize_adc();
        run_scan(1, SCAN_LEN, 1'b0);     // edge in the DONE cycle is ignored
        randomize_adc();
        run_scan(1, SCAN_LEN + 1, 1'b0); // edge in first IDLE cycle starts a scan

        // reset in the middle of frame 2
        randomize_adc();
        const_mode = 1'b0;
        clr_gen++;
        @(negedge clk);
        @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        for (int t = 0; t < 6000 && q_fall.size() < 3; t++) @(negedge clk);
        check("rst_reach_frame2", 32'(q_fall.size()), 32'd3);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_dclk", 32'(dclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_eos", 32'(eos), 32'd0);
        check("rst_dout0", 32'(dout0), 32'd0);
        check("rst_dout3", 32'(dout3), 32'd0);
        clr_gen++;
        repeat (SCAN_LEN + 300) @(negedge clk);
        check("rst_no_eos", 32'(eos_cnt), 32'd0);
        check("rst_no_frames", 32'(q_fall.size()), 32'd0);
        randomize_adc();
        run_scan(1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
